// File: rtl/apv_event_builder_if.sv
// Output word stream of one APV channel event builder toward the MPD event
// merger: a 32-bit word qualified by OUT_VALID and accepted with OUT_READY.
interface apv_event_builder_if;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;

    modport master (output OUT_DATA, output OUT_VALID, input OUT_READY);
    modport slave  (input OUT_DATA, input OUT_VALID, output OUT_READY);
endinterface

// File: rtl/apv_event_builder.sv
// Per-channel APV frame builder. Pops one frame (header, N_SAMPLES analog
// words, trailer) from the channel data FIFO, checks its format, subtracts
// the frame baseline from each sample and packs two samples per 32-bit word
// on a valid/ready stream.
// Build option BASELINE_SUB_EN: when defined, the baseline comes from the
// show-ahead mean FIFO, a frame starts only once the mean FIFO holds an
// entry, and the entry is popped after the frame. When undefined, samples
// pass through unsubtracted and the mean FIFO ports are ignored.
module apv_event_builder #(
    parameter int N_SAMPLES = 128,
    parameter int CH_ID_W   = 4
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic               ENABLE,
    input  logic [CH_ID_W-1:0] CH_ID,
    input  logic               ERR_CLR,
    input  logic [12:0]        DATA_IN,
    input  logic               DATA_EMPTY,
    output logic               DATA_RD,
    input  logic               ONE_MORE_EVENT,
    input  logic [11:0]        MEAN,
    output logic               RD_NEXT_MEAN,
    apv_event_builder_if.master out_if,
    output logic               BUSY,
    output logic               FRAME_ERR,
    output logic [7:0]         ERR_CNT
);

    typedef enum logic [3:0] {
        IDLE, RD_HDR, CAP_HDR, RD_EVN, CAP_EVN,
        RD_ODD, CAP_ODD, RD_TRL, CAP_TRL, POP
    } state_t;

    localparam int               CNT_W     = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N_SAMPLES - 2);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [11:0]        mean_q;
    logic signed [13:0] d0_p1;
    logic signed [13:0] d1;
    logic [3:0]         ch_tag;
    logic               start;
    logic               rd_ok;
    logic               load;
    logic [31:0]        load_word;

    // Sample minus baseline; the 14-bit result always fits (-4095..8191).
    function automatic logic signed [13:0] base_sub(input logic [12:0] s,
                                                    input logic [11:0] m);
        logic signed [13:0] a;
        logic signed [13:0] b;
        a = signed'({1'b0, s});
        b = signed'({2'b00, m});
        return a - b;
    endfunction

    assign ch_tag = 4'(CH_ID);

    // Only one word may be in flight: read when data exists and the output
    // register is empty or being drained this cycle.
    assign rd_ok = !DATA_EMPTY && (!out_if.OUT_VALID || out_if.OUT_READY);

`ifdef BASELINE_SUB_EN
    assign start = ENABLE && ONE_MORE_EVENT;

    // Freeze the baseline of the frame about to start for its whole duration
    always_ff @(posedge CLK) begin
        if (state == IDLE && start) begin
            mean_q <= MEAN;
        end
    end
`else
    logic unused_inputs;

    assign start         = ENABLE && !DATA_EMPTY;
    assign mean_q        = 12'h000;
    assign unused_inputs = ^{ONE_MORE_EVENT, MEAN};
`endif

    assign d1 = base_sub(DATA_IN, mean_q);

    // Hold the even sample's difference until its odd partner arrives
    always_ff @(posedge CLK) begin
        if (state == CAP_EVN) begin
            d0_p1 <= d1;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: every read state waits for its read, then captures
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD_HDR;
            RD_HDR:  if (rd_ok) state_nx = CAP_HDR;
            CAP_HDR: state_nx = RD_EVN;
            RD_EVN:  if (rd_ok) state_nx = CAP_EVN;
            CAP_EVN: state_nx = RD_ODD;
            RD_ODD:  if (rd_ok) state_nx = CAP_ODD;
            CAP_ODD: state_nx = (cnt == LAST_PAIR) ? RD_TRL : RD_EVN;
            RD_TRL:  if (rd_ok) state_nx = CAP_TRL;
`ifdef BASELINE_SUB_EN
            CAP_TRL: state_nx = POP;
`else
            CAP_TRL: state_nx = IDLE;
`endif
            POP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: FIFO strobes, format checks and the word to load
    always_comb begin
        DATA_RD      = 1'b0;
        RD_NEXT_MEAN = 1'b0;
        FRAME_ERR    = 1'b0;
        load         = 1'b0;
        load_word    = 32'h0;
        BUSY         = (state != IDLE);
        case (state)
            RD_HDR, RD_EVN, RD_ODD, RD_TRL: DATA_RD = rd_ok;
            CAP_HDR: begin
                load      = 1'b1;
                load_word = {4'h8, ch_tag, 12'h000, DATA_IN[11:0]};
                FRAME_ERR = DATA_IN[12] || (DATA_IN[11:9] != 3'b111);
            end
            CAP_ODD: begin
                load      = 1'b1;
                load_word = {2'b00, d1, 2'b00, d0_p1};
            end
            CAP_TRL: begin
                load      = 1'b1;
                load_word = {4'hC, ch_tag, mean_q, DATA_IN[7:0], 4'h0};
                FRAME_ERR = |DATA_IN[12:8];
            end
`ifdef BASELINE_SUB_EN
            POP:     RD_NEXT_MEAN = 1'b1;
`endif
            default: ;
        endcase
    end

    // Sample counter, two samples per packed word, restarted in IDLE
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == CAP_ODD) begin
            cnt <= cnt + CNT_W'(2);
        end
    end

    // Output register: load on capture, hold under backpressure, clear on drain
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            out_if.OUT_DATA  <= 32'h0;
            out_if.OUT_VALID <= 1'b0;
        end else if (load) begin
            out_if.OUT_DATA  <= load_word;
            out_if.OUT_VALID <= 1'b1;
        end else if (out_if.OUT_VALID && out_if.OUT_READY) begin
            out_if.OUT_DATA  <= 32'h0;
            out_if.OUT_VALID <= 1'b0;
        end
    end

    // Saturating format-error counter; a clear wins over a same-cycle error
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            ERR_CNT <= 8'h00;
        end else if (ERR_CLR) begin
            ERR_CNT <= 8'h00;
        end else if (FRAME_ERR && ERR_CNT != 8'hFF) begin
            ERR_CNT <= ERR_CNT + 8'h01;
        end
    end

endmodule

// File: tb/tb_apv_event_builder.sv
// Bench for apv_event_builder: models both FIFOs as queues, builds the
// expected output words of each frame from the frame contents, and compares
// every transferred word plus handshake, error and pop behaviour.
module tb_apv_event_builder;

    localparam int NS = 128;
    localparam int FW = NS + 2;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        ENABLE;
    logic [3:0]  CH_ID;
    logic        ERR_CLR;
    logic [12:0] DATA_IN;
    logic        DATA_EMPTY;
    logic        DATA_RD;
    logic        ONE_MORE_EVENT;
    logic [11:0] MEAN;
    logic        RD_NEXT_MEAN;
    logic        BUSY;
    logic        FRAME_ERR;
    logic [7:0]  ERR_CNT;

    apv_event_builder_if bus ();

    apv_event_builder #(.N_SAMPLES(NS), .CH_ID_W(4)) dut (
        .CLK(CLK), .RSTb(RSTb), .ENABLE(ENABLE), .CH_ID(CH_ID),
        .ERR_CLR(ERR_CLR), .DATA_IN(DATA_IN), .DATA_EMPTY(DATA_EMPTY),
        .DATA_RD(DATA_RD), .ONE_MORE_EVENT(ONE_MORE_EVENT), .MEAN(MEAN),
        .RD_NEXT_MEAN(RD_NEXT_MEAN), .out_if(bus.master), .BUSY(BUSY),
        .FRAME_ERR(FRAME_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] dq[$];
    logic [11:0] mq[$];
    logic [31:0] expq[$];
    bit          exphq[$];

    logic [3:0]  ch = 4'hC;
    int cyc = 0, hdr_rd_cyc = 0, word_idx = 0;
    int stall_at = -1, hold_cnt = 0, low_cnt = 0;
    bit rand_ready = 0;
    int n_words = 0, bad_total = 0, seen_err = 0, err_model = 0;
    int exp_pops = 0, seen_pops = 0;
    logic        busy_s = 1'b0;
    logic        prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_od = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [13:0] diff14(input int s, input int m);
        int d;
        d = s - m;
        return 14'(d);
    endfunction

    // Queue one frame into the FIFO models and its expected words into the scoreboard
    task automatic push_frame(input logic [12:0] hdr, input logic [12:0] trl,
                              input logic [11:0] mean, input int kind);
        logic [12:0] s [NS];
        logic [11:0] m;
`ifdef BASELINE_SUB_EN
        m = mean;
        mq.push_back(mean);
        exp_pops++;
`else
        m = 12'h000;
`endif
        for (int k = 0; k < NS; k++) begin
            case (kind)
                0:       s[k] = 13'(32'h200 + k);
                2:       s[k] = (k == 0) ? 13'h0000 : (k == 1) ? 13'h0FFF : 13'($urandom);
                default: s[k] = 13'($urandom);
            endcase
        end
        dq.push_back(hdr);
        for (int k = 0; k < NS; k++) dq.push_back(s[k]);
        dq.push_back(trl);
        expq.push_back({4'h8, ch, 12'h000, hdr[11:0]});
        exphq.push_back(1'b1);
        for (int k = 0; k < NS; k += 2) begin
            expq.push_back({2'b00, diff14(int'(s[k+1]), int'(m)), 2'b00, diff14(int'(s[k]), int'(m))});
            exphq.push_back(1'b0);
        end
        expq.push_back({4'hC, ch, m, trl[7:0], 4'h0});
        exphq.push_back(1'b0);
        if (!(hdr >= 13'h0E00 && hdr <= 13'h0FFF)) begin bad_total++; if (err_model < 255) err_model++; end
        if (trl > 13'h00FF) begin bad_total++; if (err_model < 255) err_model++; end
    endtask

    // One clock: observe at the falling edge, update the FIFO models after the rising edge
    task automatic tick();
        logic rd, nm, vld, rdy;
        logic [31:0] od;
        @(negedge CLK);
        cyc++;
        rd = DATA_RD; nm = RD_NEXT_MEAN; busy_s = BUSY;
        vld = bus.OUT_VALID; rdy = bus.OUT_READY; od = bus.OUT_DATA;
        if (DATA_EMPTY || (vld && !rdy)) check_eq("rd_gate", rd, 1'b0);
        if (prev_vld && !prev_rdy) begin
            check_eq("hold_valid", vld, 1'b1);
            check_eq("hold_data", od, prev_od);
        end
        if (vld && !prev_vld && exphq.size() != 0 && exphq[0])
            check_eq("hdr_latency", cyc - hdr_rd_cyc, 2);
        if (vld && rdy) begin
            n_words++;
            check_eq("word_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                check_eq("out_word", od, expq.pop_front());
                void'(exphq.pop_front());
            end
        end
        if (FRAME_ERR) seen_err++;
        if (nm) seen_pops++;
        prev_vld = vld; prev_rdy = rdy; prev_od = od;
        @(posedge CLK);
        #1;
        if (hold_cnt > 0) hold_cnt--;
        if (rd && dq.size() != 0) begin
            if (word_idx == 0) hdr_rd_cyc = cyc;
            DATA_IN = dq.pop_front();
            if (word_idx == stall_at) begin hold_cnt = 20; stall_at = -1; end
            word_idx = (word_idx + 1) % FW;
        end
        if (nm && mq.size() != 0) void'(mq.pop_front());
        DATA_EMPTY = (dq.size() == 0) || (hold_cnt > 0);
`ifdef BASELINE_SUB_EN
        ONE_MORE_EVENT = (mq.size() != 0);
        MEAN = (mq.size() != 0) ? mq[0] : 12'($urandom);
`else
        ONE_MORE_EVENT = 1'($urandom_range(0, 1));
        MEAN = 12'($urandom);
`endif
        if (low_cnt > 0) begin
            bus.OUT_READY = 1'b0;
            low_cnt--;
        end else begin
            bus.OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic wait_drain(input string tag, input int remaining, input int budget);
        int n;
        n = 0;
        while ((expq.size() != remaining || busy_s) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n < budget), 1);
    endtask

    task automatic check_quiet_outs();
        check_eq("rst_data", bus.OUT_DATA, 32'h0);
        check_eq("rst_valid", bus.OUT_VALID, 1'b0);
        check_eq("rst_rd", DATA_RD, 1'b0);
        check_eq("rst_pop", RD_NEXT_MEAN, 1'b0);
        check_eq("rst_busy", BUSY, 1'b0);
        check_eq("rst_ferr", FRAME_ERR, 1'b0);
        check_eq("rst_errcnt", ERR_CNT, 8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, pops_snap, n;
        RSTb = 1'b0; ENABLE = 1'b0; ERR_CLR = 1'b0; CH_ID = ch;
        DATA_IN = 13'h0; DATA_EMPTY = 1'b1; ONE_MORE_EVENT = 1'b0; MEAN = 12'h0;
        bus.OUT_READY = 1'b1;
        repeat (3) tick();
        check_quiet_outs();
        RSTb = 1'b1;
        repeat (2) tick();

        // Nominal frame
        w0 = n_words;
        push_frame(13'h0E01, 13'h0005, 12'h100, 0);
        ENABLE = 1'b1;
        wait_drain("drain_nominal", 0, 3000);
        check_eq("words_nominal", n_words - w0, 66);
        check_eq("errcnt_nominal", ERR_CNT, 8'h00);
        check_eq("pops_nominal", seen_pops, exp_pops);

        // Negative differences
        push_frame(13'h0E01, 13'h0005, 12'hFFF, 2);
        wait_drain("drain_negative", 0, 3000);

        // Backpressure window mid-frame
        w0 = n_words;
        push_frame(13'h0FAB, 13'h00C3, 12'($urandom), 1);
        repeat (40) tick();
        low_cnt = 10;
        wait_drain("drain_backpressure", 0, 3000);
        check_eq("words_backpressure", n_words - w0, 66);

        // Bad header and bad trailer
        w0 = n_words; e0 = seen_err;
        push_frame(13'h0A01, 13'h0105, 12'($urandom), 1);
        wait_drain("drain_bad", 0, 3000);
        check_eq("words_bad", n_words - w0, 66);
        check_eq("ferr_pulses_bad", seen_err - e0, 2);
        check_eq("errcnt_bad", ERR_CNT, 32'(err_model));
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        err_model = 0;
        tick();
        check_eq("errcnt_cleared", ERR_CNT, 8'h00);

        // Data FIFO runs dry after sample 63, then ENABLE drops
        stall_at = 64;
        push_frame(13'h0E55, 13'h0011, 12'($urandom), 1);
        n = 0;
        while (hold_cnt == 0 && n < 1000) begin tick(); n++; end
        check_eq("stall_reached", 32'(n < 1000), 1);
        repeat (3) tick();
        check_eq("stall_busy", busy_s, 1'b1);
        ENABLE = 1'b0;
        push_frame(13'h0E66, 13'h0022, 12'($urandom), 1);
        wait_drain("drain_stall", 66, 3000);
        for (int i = 0; i < 30; i++) begin
            tick();
            check_eq("disabled_idle", busy_s, 1'b0);
        end
        ENABLE = 1'b1;
        wait_drain("drain_reenable", 0, 3000);

        // Randomised frames under random backpressure
        ch = 4'h5; CH_ID = ch;
        rand_ready = 1;
        for (int f = 0; f < 4; f++) begin
            logic [12:0] h, t;
            h = ($urandom_range(0, 3) == 0) ? 13'($urandom) : {4'b0111, 9'($urandom)};
            t = ($urandom_range(0, 3) == 0) ? 13'($urandom) : {5'b0, 8'($urandom)};
            push_frame(h, t, 12'($urandom), 1);
        end
        wait_drain("drain_random", 0, 12000);
        check_eq("errcnt_random", ERR_CNT, 32'(err_model));
        check_eq("ferr_total", seen_err, bad_total);
        check_eq("pops_random", seen_pops, exp_pops);
        rand_ready = 0;

        // Reset in the middle of a frame
        push_frame(13'h0E01, 13'h0005, 12'h123, 0);
        repeat (60) tick();
        pops_snap = seen_pops;
        #2;
        RSTb = 1'b0;
        #1;
        check_quiet_outs();
        dq.delete(); mq.delete(); expq.delete(); exphq.delete();
        word_idx = 0; err_model = 0; prev_vld = 1'b0;
        DATA_EMPTY = 1'b1; ONE_MORE_EVENT = 1'b0;
        repeat (3) tick();
        RSTb = 1'b1;
        repeat (5) tick();
        check_eq("no_pop_after_reset", seen_pops, pops_snap);
        check_eq("idle_after_reset", busy_s, 1'b0);
        exp_pops = seen_pops;
        push_frame(13'h0E77, 13'h0044, 12'h0AA, 0);
        wait_drain("drain_recover", 0, 3000);
        check_eq("pops_recover", seen_pops, exp_pops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apv_event_builder.md
Name: apv_event_builder

Overview:
- Downstream consumer of one APV readout channel: pops one complete frame from the channel data FIFO and its baseline from the mean FIFO.
- A frame is header, 128 analog samples, trailer, all 13-bit words.
- Checks the frame format, subtracts the baseline from each sample and packs the result into 32-bit words.
- Drives a valid/ready stream toward the MPD event merger; one instance per APV channel.

Parameters:
- N_SAMPLES, 128, analog words per frame (even).
- CH_ID_W, 4, width of the channel tag.

Ports:
- CLK  in  1  clock, same domain as the FIFO read side.
- RSTb  in  1  asynchronous, active-low reset.
- ENABLE  in  1  allows a new frame to start.
- CH_ID  in  CH_ID_W  channel tag inserted in header and trailer.
- ERR_CLR  in  1  synchronous clear of ERR_CNT.
- DATA_IN  in  13  data FIFO q; valid the cycle after DATA_RD.
- DATA_EMPTY  in  1  data FIFO empty.
- DATA_RD  out  1  data FIFO read request.
- ONE_MORE_EVENT  in  1  mean FIFO non-empty, meaning at least one complete frame is stored.
- MEAN  in  12  show-ahead baseline of the oldest frame.
- RD_NEXT_MEAN  out  1  mean FIFO pop, one-cycle pulse.
- OUT_DATA  out  32  packed output word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  consumer accepts the word.
- BUSY  out  1  frame in progress.
- FRAME_ERR  out  1  one-cycle pulse on a format error.
- ERR_CNT  out  8  saturating error counter.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal sample counter 0.
- Read gate: DATA_RD=1 only in a read state with DATA_EMPTY=0 and (OUT_VALID=0 or OUT_READY=1). The word is captured on the next cycle. There is at most one word in flight, so throughput is one input word per 2 cycles maximum.
- FSM states:
  - IDLE: move to RD_HDR when ENABLE=1 and ONE_MORE_EVENT=1. Latch MEAN into mean_q.
  - RD_HDR to CAP_HDR: header word H.
    - Error if H[12]=1 or H[11:9]!=3'b111.
    - Output {4'h8, CH_ID, 12'h000, H[11:0]}.
  - RD_EVN to CAP_EVN: capture even sample s0.
  - RD_ODD to CAP_ODD: capture odd sample s1.
    - Output {2'b00, d1[13:0], 2'b00, d0[13:0]}, where d = {1'b0,s} - {2'b00,mean_q} as 14-bit two's complement.
    - Range is -4095..8191, so there is no overflow and no saturation.
    - Counter += 2. Return to RD_EVN until the counter equals N_SAMPLES.
  - RD_TRL to CAP_TRL: trailer T.
    - Error if T[12:8]!=0.
    - Output {4'hC, CH_ID, mean_q, T[7:0], 4'h0}.
  - POP: RD_NEXT_MEAN=1 for 1 cycle, then IDLE.
- Output register:
  - Loaded only in CAP_HDR, CAP_ODD and CAP_TRL.
  - Holds while OUT_VALID=1 and OUT_READY=0.
  - Cleared when the word is transferred and no new load occurs in that cycle.
- Latency: DATA_RD for the header at cycle t gives OUT_VALID with the header word at t+2.
- Frame length: 66 output words per frame.
- BUSY: 1 from leaving IDLE until the POP cycle, inclusive.
- Errors:
  - FRAME_ERR pulses in the capture cycle of a bad header or trailer. The frame is still fully consumed and emitted to keep both FIFOs aligned.
  - ERR_CNT +1 per error, saturating at 255.
  - ERR_ACC ERR_CLR has priority over an increment in the same cycle.
- ENABLE dropped mid-frame: the current frame completes; no new frame starts.
- DATA_EMPTY mid-frame: the FSM stalls in the current read state with no timeout.
- Reset mid-frame: immediate return to IDLE, no pop. FIFO alignment is restored by the system FIFO clear.
- MEAN changing after the IDLE latch has no effect on the current frame.

Optional Feature:
- Macro BASELINE_SUB_EN.
- Defined:
  - IDLE start requires ONE_MORE_EVENT.
  - d = s - mean_q.
  - POP state present.
- Undefined:
  - IDLE start requires ENABLE=1 and DATA_EMPTY=0.
  - mean_q forced to 0, so d = {1'b0,s} and the trailer mean field is 0.
  - RD_NEXT_MEAN tied 0; POP state skipped (CAP_TRL goes to IDLE).
  - The ONE_MORE_EVENT and MEAN inputs are ignored.

Test Plan:
- Nominal frame: MEAN=12'h100, H=0x0E01, samples s_k=0x200+k, T=0x005, OUT_READY=1.
  - Expect 66 words: 0x8<CH>000E01, first data 0x01010100, trailer 0xC<CH>100050.
  - One RD_NEXT_MEAN pulse; ERR_CNT=0.
- Negative result: MEAN=0xFFF, sample 0x000.
  - Expect d=14'h3001 (-4095) in the low field; a marker sample 0x0FFF gives 0x0000.
- Backpressure: OUT_READY low for 10 cycles mid-frame.
  - OUT_DATA is stable while OUT_VALID=1; DATA_RD stays 0; no word is lost or duplicated; the total is still 66.
- Bad header 0x0A01 and bad trailer 0x105.
  - Two FRAME_ERR pulses; ERR_CNT=2; 66 words still emitted.
  - ERR_CLR then gives ERR_CNT=0.
- DATA_EMPTY asserted for 20 cycles after sample 63, then ENABLE dropped.
  - The FSM stalls, resumes and finishes the frame; it stays in IDLE with BUSY=0 while ONE_MORE_EVENT=1.
- RSTb pulsed low mid-frame.
  - All outputs are 0 at once; IDLE; RD_NEXT_MEAN not pulsed.
